// File: rtl/hex_display_pkg.sv
// Shared types and glyph helpers for the HEX display arbiter.
// Segment vectors are active-low, index 0 = dp, 1 = g, ... 7 = a.
package hex_display_pkg;

  typedef enum logic [1:0] {
    SW_VIEW    = 2'd0,
    EXT_OWN    = 2'd1,
    SW_RECLAIM = 2'd2
  } state_t;

  typedef logic [0:7] seg_t;

  localparam seg_t SEG_BLANK = 8'b11111111;
  localparam seg_t SEG_ZERO  = 8'b11000000;
  localparam seg_t SEG_ONE   = 8'b11111001;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = 8'b11000000;
      4'h1: seg = 8'b11111001;
      4'h2: seg = 8'b10100100;
      4'h3: seg = 8'b10110000;
      4'h4: seg = 8'b10011001;
      4'h5: seg = 8'b10010010;
      4'h6: seg = 8'b10000010;
      4'h7: seg = 8'b11111000;
      4'h8: seg = 8'b10000000;
      4'h9: seg = 8'b10010000;
      4'hA: seg = 8'b10001000;
      4'hB: seg = 8'b10000011;
      4'hC: seg = 8'b11000110;
      4'hD: seg = 8'b10100001;
      4'hE: seg = 8'b10000110;
      4'hF: seg = 8'b10001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability counter; change_o pulses
// for one cycle on the same edge any debounced bit flips.
module switch_debouncer #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o,
  output logic             change_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] deb_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic             change_q;

  // NOTE: state is updated with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      deb_q    <= '0;
      change_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      change_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i]  <= '0;
          deb_q[i]  <= sync_q[i];
          change_q  <= 1'b1;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign deb_o    = deb_q;
  assign change_o = change_q;

endmodule

// File: rtl/hex_display_arbiter.sv
// Arbitrates the six-digit HEX bank between the debounced switch view and an
// external req/grant message source, with a minimum hold per ownership.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic        MAX10_CLK1_50,
  input  logic        KEY0,
  input  logic [0:5]  SW,
  output logic [0:5]  LEDR,
  output logic [0:7]  HEX0,
  output logic [0:7]  HEX1,
  output logic [0:7]  HEX2,
  output logic [0:7]  HEX3,
  output logic [0:7]  HEX4,
  output logic [0:7]  HEX5,
  input  logic        ext_req,
  input  logic [23:0] ext_data,
  output logic        ext_gnt
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  logic [5:0]        sw_raw;
  logic [5:0]        sw_deb;
  logic              sw_change;
  state_t            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_dec;
  logic              hold_expired;
  logic              sw_pending_q;
  logic              ext_gnt_q;
  seg_t              hex_d [6];
  seg_t              hex_q [6];

  // Internal vectors use bit i for SW[i] / LEDR[i] / HEXi.
  always_comb begin
    for (int i = 0; i < 6; i++) sw_raw[i] = SW[i];
  end

  always_comb begin
    for (int i = 0; i < 6; i++) LEDR[i] = sw_deb[i];
  end

  switch_debouncer #(
    .WIDTH          (6),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk     (MAX10_CLK1_50),
    .rst_n   (KEY0),
    .raw_i   (sw_raw),
    .deb_o   (sw_deb),
    .change_o(sw_change)
  );

  assign hold_expired = (hold_q == '0);
  assign hold_dec     = hold_expired ? '0 : hold_q - 1'b1;

  // ext_gnt is assigned alongside every state change so it always equals
  // (state_q == EXT_OWN) without a decode glitch.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!KEY0) begin
      state_q      <= SW_VIEW;
      hold_q       <= '0;
      sw_pending_q <= 1'b0;
      ext_gnt_q    <= 1'b0;
    end else begin
      case (state_q)
        SW_VIEW: begin
          if (ext_req && hold_expired) begin
            state_q   <= EXT_OWN;
            hold_q    <= HOLD_RELOAD;
            ext_gnt_q <= 1'b1;
          end else begin
            hold_q <= hold_dec;
          end
        end
        EXT_OWN: begin
          if (!ext_req) begin
            // Switch view is shown right away, so any pending change is moot.
            state_q      <= SW_VIEW;
            hold_q       <= '0;
            sw_pending_q <= 1'b0;
            ext_gnt_q    <= 1'b0;
          end else if (hold_expired && (sw_pending_q || sw_change)) begin
            state_q      <= SW_RECLAIM;
            hold_q       <= HOLD_RELOAD;
            sw_pending_q <= 1'b0;
            ext_gnt_q    <= 1'b0;
          end else begin
            hold_q <= hold_dec;
            if (sw_change) sw_pending_q <= 1'b1;
          end
        end
        SW_RECLAIM: begin
          if (hold_expired) begin
            if (ext_req) begin
              state_q   <= EXT_OWN;
              hold_q    <= HOLD_RELOAD;
              ext_gnt_q <= 1'b1;
            end else begin
              state_q <= SW_VIEW;
            end
          end else begin
            hold_q <= hold_dec;
          end
        end
        default: begin
          state_q   <= SW_VIEW;
          hold_q    <= '0;
          ext_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: every output of this block is assigned on every path, so no latch.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      hex_d[i] = SEG_ZERO;
      if (state_q == EXT_OWN) hex_d[i] = hex_to_seg(ext_data[4*i +: 4]);
      else if (sw_deb[i])     hex_d[i] = SEG_ONE;
    end
  end

  // NOTE: this is six flip-flop registers, not a RAM, so resetting them is fine.
  always_ff @(posedge MAX10_CLK1_50) begin
    if (!KEY0) begin
      for (int i = 0; i < 6; i++) hex_q[i] <= SEG_ZERO;
    end else begin
      for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign HEX0    = hex_q[0];
  assign HEX1    = hex_q[1];
  assign HEX2    = hex_q[2];
  assign HEX3    = hex_q[3];
  assign HEX4    = hex_q[4];
  assign HEX5    = hex_q[5];
  assign ext_gnt = ext_gnt_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with DEBOUNCE_CYCLES=4, HOLD_CYCLES=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_hex_display_arbiter;

  localparam logic [7:0] G0 = 8'b11000000;
  localparam logic [7:0] G1 = 8'b11111001;
  localparam logic [7:0] G2 = 8'b10100100;
  localparam logic [7:0] G3 = 8'b10110000;
  localparam logic [7:0] G4 = 8'b10011001;
  localparam logic [7:0] G5 = 8'b10010010;
  localparam logic [7:0] G6 = 8'b10000010;
  localparam logic [7:0] G7 = 8'b11111000;
  localparam logic [7:0] G8 = 8'b10000000;
  localparam logic [7:0] G9 = 8'b10010000;
  localparam logic [7:0] GA = 8'b10001000;
  localparam logic [7:0] GB = 8'b10000011;
  localparam logic [7:0] GC = 8'b11000110;
  localparam logic [7:0] GD = 8'b10100001;
  localparam logic [7:0] GE = 8'b10000110;
  localparam logic [7:0] GF = 8'b10001110;

  typedef struct {
    logic [23:0] data;
    logic [47:0] exp;  // {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}
  } vec_t;

  logic        clk;
  logic        key0;
  logic [0:5]  sw;
  logic [0:5]  ledr;
  logic [0:7]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic        ext_req;
  logic [23:0] ext_data;
  logic        ext_gnt;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [5];

  hex_display_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8)
  ) dut (
    .MAX10_CLK1_50(clk),
    .KEY0         (key0),
    .SW           (sw),
    .LEDR         (ledr),
    .HEX0         (hex0),
    .HEX1         (hex1),
    .HEX2         (hex2),
    .HEX3         (hex3),
    .HEX4         (hex4),
    .HEX5         (hex5),
    .ext_req      (ext_req),
    .ext_data     (ext_data),
    .ext_gnt      (ext_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_at(input int i);
    case (i)
      0:       return hex0;
      1:       return hex1;
      2:       return hex2;
      3:       return hex3;
      4:       return hex4;
      default: return hex5;
    endcase
  endfunction

  task automatic check_hex(input string name, input logic [47:0] exp);
    for (int i = 0; i < 6; i++)
      check($sformatf("%s_hex%0d", name, i), {40'd0, hex_at(i)}, {40'd0, exp[8*i +: 8]});
  endtask

  initial begin
    vecs[0] = '{data: 24'h01234F, exp: {G0, G1, G2, G3, G4, GF}};
    vecs[1] = '{data: 24'h56789A, exp: {G5, G6, G7, G8, G9, GA}};
    vecs[2] = '{data: 24'hBCDEF0, exp: {GB, GC, GD, GE, GF, G0}};
    vecs[3] = '{data: 24'h888888, exp: {G8, G8, G8, G8, G8, G8}};
    vecs[4] = '{data: 24'hA5C3E1, exp: {GA, G5, GC, G3, GE, G1}};

    // Reset with all switches up.
    key0 = 1'b0; sw = 6'b111111; ext_req = 1'b0; ext_data = 24'h0;
    repeat (3) tick();
    check("rst_ledr", ledr, 6'b000000);
    check("rst_gnt", ext_gnt, 1'b0);
    check_hex("rst", {6{G0}});

    key0 = 1'b1;
    repeat (5) tick();
    check("rel_ledr_early", ledr, 6'b000000);
    tick();
    check("rel_ledr_c6", ledr, 6'b111111);
    check_hex("rel_hex_c6", {6{G0}});
    tick();
    check_hex("rel_hex_c7", {6{G1}});

    // Three-cycle glitch on SW[2] must be rejected.
    sw[2] = 1'b0;
    repeat (3) tick();
    sw[2] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("glitch_ledr_c%0d", c), ledr, 6'b111111);
    end

    // Stable change on SW[2], both directions, exactly 6 cycles of latency.
    sw[2] = 1'b0;
    repeat (5) tick();
    check("fall_ledr_c5", ledr, 6'b111111);
    tick();
    check("fall_ledr_c6", ledr, 6'b110111);
    tick();
    check_hex("fall_view", {G1, G1, G1, G0, G1, G1});
    sw[2] = 1'b1;
    repeat (5) tick();
    check("rise_ledr_c5", ledr, 6'b110111);
    tick();
    check("rise_ledr_c6", ledr, 6'b111111);
    tick();
    check_hex("rise_view", {6{G1}});

    // Grant from SW_VIEW.
    ext_req = 1'b1; ext_data = 24'h01234F;
    tick();
    check("grant_gnt", ext_gnt, 1'b1);
    tick();
    check_hex("grant_view", {G0, G1, G2, G3, G4, GF});

    // Switch flip during ownership: reclaim once the hold expires.
    sw[0] = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      check($sformatf("own_gnt_c%0d", c), ext_gnt, 1'b1);
    end
    check("own_ledr_c7", ledr, 6'b011111);
    tick();
    check("reclaim_gnt_c8", ext_gnt, 1'b0);
    for (int c = 9; c <= 15; c++) begin
      tick();
      check($sformatf("reclaim_gnt_c%0d", c), ext_gnt, 1'b0);
      if (c == 9) check_hex("reclaim_view", {G1, G1, G1, G1, G1, G0});
    end
    tick();
    check("regrant_gnt_c16", ext_gnt, 1'b1);

    // Glyph table while the external source owns the display.
    for (int v = 0; v < 5; v++) begin
      ext_data = vecs[v].data;
      tick();
      check_hex($sformatf("vec%0d", v), vecs[v].exp);
      check($sformatf("vec%0d_gnt", v), ext_gnt, 1'b1);
    end

    // Voluntary release and immediate re-request.
    ext_req = 1'b0;
    tick();
    check("release_gnt", ext_gnt, 1'b0);
    tick();
    check_hex("release_view", {G1, G1, G1, G1, G1, G0});
    ext_req = 1'b1;
    tick();
    check("rereq_gnt", ext_gnt, 1'b1);
    repeat (2) tick();
    ext_req = 1'b0;
    tick();
    check("early_release_gnt", ext_gnt, 1'b0);
    ext_req = 1'b1;
    tick();
    check("early_rereq_gnt", ext_gnt, 1'b1);

    // Build up a pending switch change, then reset mid-grant.
    sw = 6'b000000;
    repeat (7) tick();
    check("pre_rst_ledr", ledr, 6'b000000);
    check("pre_rst_gnt", ext_gnt, 1'b1);
    key0 = 1'b0;
    tick();
    check("midrst_gnt", ext_gnt, 1'b0);
    check("midrst_ledr", ledr, 6'b000000);
    check_hex("midrst", {6{G0}});
    key0 = 1'b1;
    tick();
    check("post_rst_gnt", ext_gnt, 1'b1);
    for (int c = 0; c < 12; c++) begin
      tick();
      check($sformatf("no_pending_gnt_c%0d", c), ext_gnt, 1'b1);
    end
    check_hex("post_rst_view", {GA, G5, GC, G3, GE, G1});

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
Name: hex_display_arbiter

Overview:
- Shares the six-digit HEX bank (HEX0..HEX5) between two requesters:
  - the live switch view, where each debounced switch shows 0 or 1 on its digit;
  - an external hex-message source using a req/grant handshake.
- Debounces SW[0:5], mirrors the debounced switches on LEDR, and enforces a minimum ownership time so neither requester starves.
- Sits directly under the board top level, between the board switches/displays and any message-producing logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized switch must be stable before acceptance (10 ms at 50 MHz).
- HOLD_CYCLES, 50000000, minimum cycles an owner keeps the display once granted (1 s at 50 MHz).

Ports:
- MAX10_CLK1_50  in  1  system clock; all logic on the rising edge.
- KEY0  in  1  reset, synchronous, active-low.
- SW  in  [0:5]  raw slide switches, asynchronous to the clock.
- LEDR  out  [0:5]  debounced switch state.
- HEX0..HEX5  out  [0:7] each  seven-segment digits, active-low, index 0=dp, 1=g, 2=f, 3=e, 4=d, 5=c, 6=b, 7=a.
- ext_req  in  1  external source requests the display.
- ext_data  in  24  six nibbles; [23:20] drive HEX5 ... [3:0] drive HEX0.
- ext_gnt  out  1  external source currently owns the display.

Behaviour:
- Reset (KEY0 low at a clock edge):
  - all outputs are driven to these values: LEDR=0, ext_gnt=0, every HEX = 8'b11000000 (digit 0);
  - state goes to SW_VIEW, counters cleared, sw_pending=0, debounced state = 0.
  - Reset mid-grant drops ext_gnt on that same edge.
- Synchronizer: 2 flops per switch; its outputs feed the debouncer.
- Debounce (per bit):
  - counter restarts whenever the synchronized value differs from the debounced value;
  - debounced bit flips after DEBOUNCE_CYCLES consecutive differing cycles.
  - Latency from the SW edge to the LEDR change is 2 + DEBOUNCE_CYCLES cycles.
- sw_change: one-cycle pulse when any debounced bit flips.
- Switch view: HEX_i = 8'b11111001 if debounced SW[i]=1, else 8'b11000000.
- Ext view: nibble-to-glyph for 0-F, active-low, dp always off (index 0 = 1).
- Outputs are registered: a HEX update appears one cycle after the state or data change.
- FSM states: SW_VIEW, EXT_OWN, SW_RECLAIM.
- SW_VIEW:
  - display shows the switch view; ext_gnt=0.
  - If ext_req=1 and hold_cnt has expired, go to EXT_OWN, reload hold_cnt, and assert ext_gnt the next cycle.
  - On first entry after reset, hold_cnt is already expired.
- EXT_OWN:
  - display shows ext_data, sampled every cycle; ext_gnt=1.
  - A sw_change pulse sets sw_pending.
  - If ext_req=0, go to SW_VIEW immediately; hold_cnt is treated as expired so a re-request is granted next cycle.
  - Otherwise, if hold_cnt has expired and sw_pending=1, go to SW_RECLAIM, reload hold_cnt, and clear sw_pending.
- SW_RECLAIM:
  - switch view shown; ext_gnt=0.
  - After hold_cnt expires: if ext_req=1, go to EXT_OWN with a reload; otherwise go to SW_VIEW.
- Simultaneous events: sw_change in the same cycle as hold expiry counts as pending, and the transition to SW_RECLAIM occurs on that edge.
- hold_cnt: down-counter, saturating at 0, wide enough for HOLD_CYCLES.
- Glitch-free ownership: ext_gnt changes only on a state transition and equals (state==EXT_OWN).

Decomposition:
- Package hex_display_pkg holds:
  - the state enum {SW_VIEW, EXT_OWN, SW_RECLAIM};
  - localparams SEG_BLANK=8'b11111111, SEG_ZERO=8'b11000000, SEG_ONE=8'b11111001;
  - function hex_to_seg(nibble) returning [0:7].
- One sub-module, switch_debouncer:
  - parameterised width and DEBOUNCE_CYCLES;
  - ports: clock, reset, raw in, debounced out, change pulse;
  - instantiated once, width 6.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
- Reset check: hold KEY0=0 for 3 cycles with SW=6'b111111 → LEDR=0, all HEX=8'b11000000, ext_gnt=0. Release → LEDR=6'b111111 at cycle 6 after release; HEX0..HEX5=8'b11111001 one cycle later.
- Debounce: toggle SW[2] for 3 cycles then restore → LEDR unchanged. Hold SW[2]=1 for 10 cycles → LEDR[2]=1 exactly 6 cycles after the edge.
- Grant path: ext_req=1, ext_data=24'h01234F in SW_VIEW → ext_gnt=1 next cycle. HEX0 shows F (8'b10001110), HEX5 shows 0 (8'b11000000).
- Reclaim: while ext owns, flip SW[0] at grant+2 → ext_gnt falls at grant+8. Switch view is held 8 cycles, then ext_gnt returns while ext_req stays high.
- Release: drop ext_req 3 cycles into EXT_OWN → ext_gnt=0 next cycle; switch view shown. Re-raise ext_req → granted the following cycle.
- Reset mid-grant: KEY0=0 during EXT_OWN → ext_gnt=0 and HEX=8'b11000000 at that edge; sw_pending cleared.
